// File: rtl/core_ctrl.sv
// Sequencer for the core's 34-bit instruction bus: per-kij conv passes, then the PMEM->SFP accumulation pass.
// Build option: define CORE_CTRL_OVERLAP_EN to run the OFIFO->PMEM drain concurrently with EXEC.
module core_ctrl #(
  parameter logic [5:0]  COL            = 6'd8,
  parameter logic [5:0]  LEN_NIJ        = 6'd36,
  parameter logic [5:0]  LEN_NIJ_DIM_1  = 6'd6,
  parameter logic [3:0]  LEN_KIJ        = 4'd9,
  parameter logic [3:0]  LEN_KIJ_DIM_1  = 4'd3,
  parameter logic [4:0]  LEN_ONIJ       = 5'd16,
  parameter logic [3:0]  LEN_ONIJ_DIM_1 = 4'd4,
  parameter logic [5:0]  CLR_CYC        = 6'd6,
  parameter logic [10:0] W_BASE         = 11'h400,
  parameter logic [10:0] A_BASE         = 11'h000,
  parameter logic [10:0] P_BASE         = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_clr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx,
  output logic        sfp_vld
);

  localparam logic [33:0] IDLE_INST = 34'h1800C0000;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LD_K, S_K_DRAIN, S_EXEC, S_OF_WAIT, S_OF_RD,
    S_A_CLR, S_A_RD, S_A_FIN, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  kij_q, kij_d;
  logic [4:0]  onij_q, onij_d;
  logic [10:0] wbase_q, wbase_d;
  logic [10:0] pbase_q, pbase_d;
  logic [10:0] jofs_q, jofs_d;
  logic [3:0]  jcol_q, jcol_d;
  logic [10:0] oofs_q, oofs_d;
  logic [3:0]  ocol_q, ocol_d;
  logic        of_act_q, of_act_d;
  logic [5:0]  of_cnt_q, of_cnt_d;
  logic        of_done_q, of_done_d;
  logic        of_launch, kij_next, of_finish;

  logic [33:0] inst_q, inst_d;
  logic        core_clr_q, core_clr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  kij_idx_q, kij_idx_d;
  logic        sfp_vld_q, sfp_vld_d;

  logic        f_acc, f_cen_p, f_wen_p, f_cen_x, f_wen_x;
  logic [10:0] f_a_p, f_a_x;
  logic        f_ofifo_rd, f_l0_rd, f_l0_wr, f_exec, f_load;

  assign of_finish = of_act_q && (of_cnt_q == LEN_NIJ);

  // Main sequencer plus the OFIFO->PMEM drain engine, which runs on its own counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kij_d     = kij_q;
    onij_d    = onij_q;
    wbase_d   = wbase_q;
    pbase_d   = pbase_q;
    jofs_d    = jofs_q;
    jcol_d    = jcol_q;
    oofs_d    = oofs_q;
    ocol_d    = ocol_q;
    of_act_d  = of_act_q;
    of_cnt_d  = of_cnt_q;
    of_done_d = of_done_q;
    of_launch = 1'b0;
    kij_next  = 1'b0;

    if (of_act_q) begin
      if (of_finish) begin
        of_act_d  = 1'b0;
        of_done_d = 1'b1;
      end else begin
        of_cnt_d = of_cnt_q + 6'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          cnt_d     = 6'd0;
          kij_d     = 4'd0;
          wbase_d   = W_BASE;
          pbase_d   = P_BASE;
          of_done_d = 1'b0;
        end
      end
      S_CLR: begin
        if (cnt_q == CLR_CYC - 6'd1) begin
          state_d = S_LD_K;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_LD_K: begin
        if (cnt_q == COL + 6'd1) begin
          state_d = S_K_DRAIN;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_K_DRAIN: begin
        if (cnt_q == COL - 6'd1) begin
          state_d = S_EXEC;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == LEN_NIJ + COL + 6'd1) begin
          state_d = S_OF_WAIT;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
`ifdef CORE_CTRL_OVERLAP_EN
        if (ofifo_valid && !of_act_q && !of_done_q) of_launch = 1'b1;
`endif
      end
      S_OF_WAIT: begin
`ifdef CORE_CTRL_OVERLAP_EN
        if (of_done_q || of_finish) kij_next = 1'b1;
        else if (ofifo_valid && !of_act_q) of_launch = 1'b1;
`else
        if (ofifo_valid && !of_done_q) begin
          of_launch = 1'b1;
          state_d   = S_OF_RD;
        end
`endif
      end
      S_OF_RD: begin
        if (of_finish) kij_next = 1'b1;
      end
      S_A_CLR: begin
        state_d = S_A_RD;
        cnt_d   = 6'd0;
        jofs_d  = 11'd0;
        jcol_d  = 4'd0;
      end
      S_A_RD: begin
        if (cnt_q == 6'(LEN_KIJ)) begin
          state_d = S_A_FIN;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
          // Next tap: +len_nij for the psum plane, +1 within a kernel row, +row stride on wrap.
          if (jcol_q == LEN_KIJ_DIM_1 - 4'd1) begin
            jcol_d = 4'd0;
            jofs_d = jofs_q + 11'(LEN_NIJ) + 11'(LEN_NIJ_DIM_1) - 11'(LEN_KIJ_DIM_1) + 11'd1;
          end else begin
            jcol_d = jcol_q + 4'd1;
            jofs_d = jofs_q + 11'(LEN_NIJ) + 11'd1;
          end
        end
      end
      S_A_FIN: begin
        if (onij_q == LEN_ONIJ - 5'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_A_CLR;
          onij_d  = onij_q + 5'd1;
          if (ocol_q == LEN_ONIJ_DIM_1 - 4'd1) begin
            ocol_d = 4'd0;
            oofs_d = oofs_q + 11'(LEN_NIJ_DIM_1) - 11'(LEN_ONIJ_DIM_1) + 11'd1;
          end else begin
            ocol_d = ocol_q + 4'd1;
            oofs_d = oofs_q + 11'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (of_launch) begin
      of_act_d = 1'b1;
      of_cnt_d = 6'd0;
    end

    if (kij_next) begin
      cnt_d     = 6'd0;
      of_done_d = 1'b0;
      if (kij_q == LEN_KIJ - 4'd1) begin
        state_d = S_A_CLR;
        kij_d   = 4'd0;
        onij_d  = 5'd0;
        oofs_d  = 11'd0;
        ocol_d  = 4'd0;
      end else begin
        state_d = S_CLR;
        kij_d   = kij_q + 4'd1;
        wbase_d = wbase_q + 11'(COL);
        pbase_d = pbase_q + 11'(LEN_NIJ);
      end
    end
  end

  // Outputs are decoded from next-state values so every port comes straight from a flop.
  always_comb begin
    f_acc      = 1'b0;
    f_cen_p    = 1'b1;
    f_wen_p    = 1'b1;
    f_a_p      = 11'd0;
    f_cen_x    = 1'b1;
    f_wen_x    = 1'b1;
    f_a_x      = 11'd0;
    f_ofifo_rd = 1'b0;
    f_l0_rd    = 1'b0;
    f_l0_wr    = 1'b0;
    f_exec     = 1'b0;
    f_load     = 1'b0;
    core_clr_d = 1'b0;
    sfp_vld_d  = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    kij_idx_d  = kij_d;

    case (state_d)
      S_CLR, S_A_CLR: core_clr_d = 1'b1;
      S_LD_K: begin
        if (cnt_d < COL) begin
          f_cen_x = 1'b0;
          f_a_x   = wbase_d + 11'(cnt_d);
        end
        f_l0_wr = (cnt_d >= 6'd1) && (cnt_d <= COL);
        f_l0_rd = (cnt_d >= 6'd2) && (cnt_d <= COL + 6'd1);
        f_load  = f_l0_rd;
      end
      S_EXEC: begin
        if (cnt_d < LEN_NIJ) begin
          f_cen_x = 1'b0;
          f_a_x   = A_BASE + 11'(cnt_d);
        end
        f_l0_wr = (cnt_d >= 6'd1) && (cnt_d <= LEN_NIJ);
        f_l0_rd = (cnt_d >= 6'd2) && (cnt_d <= LEN_NIJ + 6'd1);
        f_exec  = f_l0_rd;
      end
      S_A_RD: begin
        if (cnt_d < 6'(LEN_KIJ)) begin
          f_cen_p = 1'b0;
          f_a_p   = P_BASE + jofs_d + oofs_d;
        end
        f_acc = (cnt_d >= 6'd1);
      end
      S_A_FIN: sfp_vld_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase

    // PMEM write trails the OFIFO read by one cycle.
    if (of_act_d) begin
      f_ofifo_rd = (of_cnt_d < LEN_NIJ);
      if (of_cnt_d != 6'd0) begin
        f_cen_p = 1'b0;
        f_wen_p = 1'b0;
        f_a_p   = pbase_d + 11'(of_cnt_d) - 11'd1;
      end
    end

    inst_d = {f_acc, f_cen_p, f_wen_p, f_a_p, f_cen_x, f_wen_x, f_a_x,
              f_ofifo_rd, 1'b0, 1'b0, f_l0_rd, f_l0_wr, f_exec, f_load};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      kij_q      <= 4'd0;
      onij_q     <= 5'd0;
      wbase_q    <= 11'd0;
      pbase_q    <= 11'd0;
      jofs_q     <= 11'd0;
      jcol_q     <= 4'd0;
      oofs_q     <= 11'd0;
      ocol_q     <= 4'd0;
      of_act_q   <= 1'b0;
      of_cnt_q   <= 6'd0;
      of_done_q  <= 1'b0;
      inst_q     <= IDLE_INST;
      core_clr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      kij_idx_q  <= 4'd0;
      sfp_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kij_q      <= kij_d;
      onij_q     <= onij_d;
      wbase_q    <= wbase_d;
      pbase_q    <= pbase_d;
      jofs_q     <= jofs_d;
      jcol_q     <= jcol_d;
      oofs_q     <= oofs_d;
      ocol_q     <= ocol_d;
      of_act_q   <= of_act_d;
      of_cnt_q   <= of_cnt_d;
      of_done_q  <= of_done_d;
      inst_q     <= inst_d;
      core_clr_q <= core_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      kij_idx_q  <= kij_idx_d;
      sfp_vld_q  <= sfp_vld_d;
    end
  end

  assign inst     = inst_q;
  assign core_clr = core_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign kij_idx  = kij_idx_q;
  assign sfp_vld  = sfp_vld_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: reset, conv-pass field timing, PMEM addressing, accumulation and restart.
// Timing expectations follow CORE_CTRL_OVERLAP_EN when the bench is built with it.
module tb_core_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [33:0] inst;
  logic        core_clr, busy, done, sfp_vld;
  logic [3:0]  kij_idx;

  int checks = 0;
  int errors = 0;

  localparam logic [33:0] IDLE_INST = 34'h1800C0000;
`ifdef CORE_CTRL_OVERLAP_EN
  localparam int KIJ_PERIOD = 71;
  localparam int OF_OFF     = 25;
`else
  localparam int KIJ_PERIOD = 108;
  localparam int OF_OFF     = 71;
`endif
  localparam int ACC_START = 9 * KIJ_PERIOD;
  localparam int DONE_CYC  = ACC_START + 16 * 12;
  localparam int OF2_BASE  = 2 * KIJ_PERIOD + OF_OFF;
  localparam int RST_CYC   = 4 * KIJ_PERIOD + 24 + 20;

  logic        acc_b, cen_p_b, wen_p_b, cen_x_b, wen_x_b;
  logic [10:0] a_p_b, a_x_b;
  logic        ofifo_rd_b, l0_rd_b, l0_wr_b, exec_b, load_b;
  assign acc_b      = inst[33];
  assign cen_p_b    = inst[32];
  assign wen_p_b    = inst[31];
  assign a_p_b      = inst[30:20];
  assign cen_x_b    = inst[19];
  assign wen_x_b    = inst[18];
  assign a_x_b      = inst[17:7];
  assign ofifo_rd_b = inst[6];
  assign l0_rd_b    = inst[3];
  assign l0_wr_b    = inst[2];
  assign exec_b     = inst[1];
  assign load_b     = inst[0];

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .core_clr(core_clr), .busy(busy), .done(done),
    .kij_idx(kij_idx), .sfp_vld(sfp_vld)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic v);
    reset       = r;
    start       = s;
    ofifo_valid = v;
  endtask

  initial begin
    int busy_cnt, sfp_cnt, wr_cnt, rd_cnt, acc_cnt, xrd_cnt, exe_cnt, load_cnt, ov_cnt, done_cyc;
    int o, j, exp_a;
    logic prev_rd, done_seen, pm_wr, pm_rd;

    // Reset held with start high: must stay idle.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_inst", 64'(inst), 64'(IDLE_INST));
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_clr", 64'(core_clr), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("idle_inst", 64'(inst), 64'(IDLE_INST));
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // Full serial/overlap run with ofifo_valid tied high; a stray start at cycle 100 is ignored.
    $display("[TB] full run");
    busy_cnt = 0; sfp_cnt = 0; wr_cnt = 0; rd_cnt = 0; acc_cnt = 0;
    xrd_cnt = 0; exe_cnt = 0; load_cnt = 0; ov_cnt = 0; done_cyc = -1;
    prev_rd = 1'b0; done_seen = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < DONE_CYC + 100 && !done_seen; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 99);
      pm_wr = !cen_p_b && !wen_p_b;
      pm_rd = !cen_p_b && wen_p_b;
      busy_cnt += int'(busy);
      sfp_cnt  += int'(sfp_vld);
      acc_cnt  += int'(acc_b);
      xrd_cnt  += int'(!cen_x_b);
      exe_cnt  += int'(exec_b);
      load_cnt += int'(load_b);
      ov_cnt   += int'(exec_b && ofifo_rd_b);

      checkOutput("wr_lags_rd", 64'(pm_wr), 64'(prev_rd));
      prev_rd = ofifo_rd_b;
      if (!cen_x_b) checkOutput("xmem_wen", 64'(wen_x_b), 64'd1);
      if (pm_wr) begin
        checkOutput("pmem_wr_addr", 64'(a_p_b), 64'(wr_cnt));
        wr_cnt++;
      end
      if (pm_rd) begin
        o = rd_cnt / 9;
        j = rd_cnt % 9;
        exp_a = j * 36 + (o / 4) * 6 + o % 4 + (j / 3) * 6 + j % 3;
        checkOutput("pmem_rd_addr", 64'(a_p_b), 64'(exp_a));
        rd_cnt++;
      end

      if (cyc <= 7) checkOutput("k0_core_clr", 64'(core_clr), 64'(cyc <= 5));
      if (cyc >= 6 && cyc <= 13) begin
        checkOutput("k0_cen_x", 64'(cen_x_b), 64'd0);
        checkOutput("k0_a_x", 64'(a_x_b), 64'(32'h400 + cyc - 6));
      end
      if (cyc >= 6 && cyc <= 16) checkOutput("k0_l0_wr", 64'(l0_wr_b), 64'(cyc >= 7 && cyc <= 14));
      if (cyc >= 6 && cyc <= 17) checkOutput("k0_load", 64'(load_b), 64'(cyc >= 8 && cyc <= 15));

      if (cyc >= OF2_BASE - 1 && cyc <= OF2_BASE + 37) begin
        checkOutput("k2_ofifo_rd", 64'(ofifo_rd_b), 64'(cyc >= OF2_BASE && cyc <= OF2_BASE + 35));
        checkOutput("k2_pmem_wr", 64'(pm_wr), 64'(cyc >= OF2_BASE + 1 && cyc <= OF2_BASE + 36));
        if (pm_wr) checkOutput("k2_a_p", 64'(a_p_b), 64'(72 + cyc - OF2_BASE - 1));
      end
      if (cyc == 2 * KIJ_PERIOD + 30) checkOutput("kij_idx_2", 64'(kij_idx), 64'd2);
      if (cyc == ACC_START + 5) checkOutput("kij_idx_acc", 64'(kij_idx), 64'd0);

      if (cyc == ACC_START + 65) begin
        checkOutput("o5j4_a_p", 64'(a_p_b), 64'd158);
        checkOutput("o5j4_cen_p", 64'(cen_p_b), 64'd0);
        checkOutput("o5j4_wen_p", 64'(wen_p_b), 64'd1);
      end
      if (cyc == ACC_START + 70) begin
        checkOutput("o5j9_acc", 64'(acc_b), 64'd1);
        checkOutput("o5j9_sfp", 64'(sfp_vld), 64'd0);
      end
      if (cyc == ACC_START + 71) begin
        checkOutput("o5fin_sfp", 64'(sfp_vld), 64'd1);
        checkOutput("o5fin_acc", 64'(acc_b), 64'd0);
      end

      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
    checkOutput("done_seen", 64'(done_seen), 64'd1);
    checkOutput("done_cycle", 64'(done_cyc), 64'(DONE_CYC));
    checkOutput("busy_cycles", 64'(busy_cnt), 64'(DONE_CYC));
    checkOutput("sfp_vld_count", 64'(sfp_cnt), 64'd16);
    checkOutput("pmem_wr_count", 64'(wr_cnt), 64'd324);
    checkOutput("pmem_rd_count", 64'(rd_cnt), 64'd144);
    checkOutput("acc_count", 64'(acc_cnt), 64'd144);
    checkOutput("xmem_rd_count", 64'(xrd_cnt), 64'd396);
    checkOutput("execute_count", 64'(exe_cnt), 64'd324);
    checkOutput("load_count", 64'(load_cnt), 64'd72);
`ifdef CORE_CTRL_OVERLAP_EN
    checkOutput("rd_exec_overlap", 64'(ov_cnt > 0), 64'd1);
`else
    checkOutput("rd_exec_overlap", 64'(ov_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    checkOutput("post_done_inst", 64'(inst), 64'(IDLE_INST));
    checkOutput("post_done_busy", 64'(busy), 64'd0);
    checkOutput("post_done_done", 64'(done), 64'd0);

    // Reset in the middle of kij=4 execution, then restart from kij=0.
    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int cyc = 0; cyc <= RST_CYC; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checkOutput("mid_exec", 64'(exec_b), 64'd1);
    checkOutput("mid_kij", 64'(kij_idx), 64'd4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("mid_rst_inst", 64'(inst), 64'(IDLE_INST));
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_kij", 64'(kij_idx), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("restart_clr", 64'(core_clr), 64'd1);
    checkOutput("restart_busy", 64'(busy), 64'd1);
    checkOutput("restart_kij", 64'(kij_idx), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("restart_a_x", 64'(a_x_b), 64'h400);
    checkOutput("restart_cen_x", 64'(cen_x_b), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
